// File: rtl/crossbar_rr_next_sel.sv
// Round-robin next-valid finder. Starting one past the current channel, it
// walks every channel once, wrapping modulo KERNEL_SIZE. The current channel
// is searched last. It reports the first valid channel found, and whether any
// channel was valid at all.
module rr_next_sel #(
    parameter int KERNEL_SIZE = 3,
    parameter int CNT_W       = 2
) (
    input  logic [CNT_W-1:0]       count,
    input  logic [KERNEL_SIZE-1:0] valid,
    output logic [CNT_W-1:0]       next_idx,
    output logic                   any_valid
);

    // Scan offsets from farthest to nearest so the nearest valid channel wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; otherwise a path
        // that assigns nothing would infer a latch.
        next_idx  = count;
        any_valid = 1'b0;
        for (int off = KERNEL_SIZE; off >= 1; off--) begin
            int idx;
            idx = int'(count) + off;
            if (idx >= KERNEL_SIZE) idx = idx - KERNEL_SIZE;
            if (valid[idx]) begin
                next_idx  = CNT_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossbar.sv
// Round-robin stream crossbar. It has KERNEL_SIZE input channels and one output.
// The selected channel is passed straight through to the output with no
// latency. The selection advances after each transfer, and it also advances
// when the selected channel is empty.
module crossbar #(
    parameter int KERNEL_SIZE = 3,
    parameter int DATA_WIDTH  = 18
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic [KERNEL_SIZE-1:0]            s_axis_tvalid,
    input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] s_axis_tdata,
    output logic [KERNEL_SIZE-1:0]            s_axis_tready,
    output logic                              m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    input  logic                              m_axis_tready
);

    localparam int CNT_W = (KERNEL_SIZE > 2) ? $clog2(KERNEL_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KERNEL_SIZE - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_idx;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] count_nxt;
    logic             any_valid;
    logic             sel_valid;
    logic             advance;

    rr_next_sel #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .CNT_W       (CNT_W)
    ) u_rr_next_sel (
        .count     (count),
        .valid     (s_axis_tvalid),
        .next_idx  (next_idx),
        .any_valid (any_valid)
    );

    // Mux the selected channel onto the output. The handshake is gated off
    // while reset is held.
    always_comb begin
        sel_valid     = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (count == CNT_W'(i)) begin
                sel_valid        = s_axis_tvalid[i];
                m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                s_axis_tready[i] = m_axis_tready & rstn;
            end
        end
        m_axis_tvalid = sel_valid & rstn;
    end

    // Pick the next channel. Hold under backpressure. If no channel is
    // valid, keep cycling through the channels.
    always_comb begin
        advance   = !sel_valid || m_axis_tready;
        count_inc = (count == LAST) ? '0 : count + 1'b1;
        count_nxt = count;
        if (advance) count_nxt = any_valid ? next_idx : count_inc;
    end

    // Channel-select register, cleared asynchronously.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignment, so every
        // register samples values from before the clock edge.
        if (!rstn) count <= '0;
        else       count <= count_nxt;
    end

endmodule

// File: tb/tb_crossbar.sv
// Directed testbench for crossbar (K=3, DATA_WIDTH=18).
// Inputs change on the falling edge. Outputs are sampled 1 ns later.
module tb_crossbar;

    localparam int K  = 3;
    localparam int DW = 18;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [K-1:0]    s_axis_tvalid = '0;
    logic [DW*K-1:0] s_axis_tdata = '0;
    logic [K-1:0]    s_axis_tready;
    logic            m_axis_tvalid;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tready = 1'b0;

    int total = 0;
    int bad   = 0;

    crossbar #(.KERNEL_SIZE(K), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tready (m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [DW*K-1:0] pack3(input int d0, input int d1, input int d2);
        return {DW'(d2), DW'(d1), DW'(d0)};
    endfunction

    // Pulse reset across one falling edge. Reset is released on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int exp_cnt[4];
        int exp_dat[4];

        // Reset state: outputs are forced low even with active inputs.
        s_axis_tvalid = 3'b111;
        s_axis_tdata  = pack3(100, 200, 300);
        m_axis_tready = 1'b1;
        #2;
        check("rst_count", 32'(dut.count), 0);
        check("rst_mvalid", 32'(m_axis_tvalid), 0);
        check("rst_sready", 32'(s_axis_tready), 0);

        // All channels valid: 100, 200, 300, 100.
        do_reset();
        exp_cnt = '{0, 1, 2, 0};
        exp_dat = '{100, 200, 300, 100};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_count", 32'(dut.count), 32'(exp_cnt[i]));
            check("rr_mvalid", 32'(m_axis_tvalid), 1);
            check("rr_data", 32'(m_axis_tdata), 32'(exp_dat[i]));
            check("rr_sready", 32'(s_axis_tready), 32'(1 << exp_cnt[i]));
            @(negedge clk);
        end

        // Only channel 1 valid: one skip, then 222 every cycle.
        s_axis_tvalid = 3'b010;
        s_axis_tdata  = pack3(111, 222, 333);
        do_reset();
        #1;
        check("single_skip_mvalid", 32'(m_axis_tvalid), 0);
        check("single_skip_count", 32'(dut.count), 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("single_count", 32'(dut.count), 1);
            check("single_data", 32'(m_axis_tdata), 222);
            check("single_sready", 32'(s_axis_tready), 32'(3'b010));
            @(negedge clk);
        end

        // Backpressure: move to channel 1, freeze there, then resume.
        s_axis_tvalid = 3'b111;
        s_axis_tdata  = pack3(10, 20, 30);
        m_axis_tready = 1'b1;
        do_reset();
        #1;
        check("bp_first_data", 32'(m_axis_tdata), 10);
        @(negedge clk);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_count", 32'(dut.count), 1);
            check("bp_mvalid", 32'(m_axis_tvalid), 1);
            check("bp_data", 32'(m_axis_tdata), 20);
            check("bp_sready", 32'(s_axis_tready), 0);
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        exp_dat = '{20, 30, 10, 20};
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_resume_data", 32'(m_axis_tdata), 32'(exp_dat[i]));
            @(negedge clk);
        end

        // Sparse channels 0 and 2: 55 and 77 alternate.
        s_axis_tvalid = 3'b101;
        s_axis_tdata  = pack3(55, 66, 77);
        do_reset();
        exp_dat = '{55, 77, 55, 77};
        for (int i = 0; i < 4; i++) begin
            #1;
            check("sparse_data", 32'(m_axis_tdata), 32'(exp_dat[i]));
            check("sparse_mvalid", 32'(m_axis_tvalid), 1);
            check("sparse_sready1", 32'(s_axis_tready[1]), 0);
            @(negedge clk);
        end

        // Dynamic change: two cycles with all channels valid, then only channel 0, then idle.
        s_axis_tvalid = 3'b111;
        s_axis_tdata  = pack3(1111, 2222, 3333);
        do_reset();
        @(negedge clk);
        @(negedge clk);
        s_axis_tvalid = 3'b001;
        #1;
        check("dyn_skip_count", 32'(dut.count), 2);
        check("dyn_skip_mvalid", 32'(m_axis_tvalid), 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("dyn_count", 32'(dut.count), 0);
            check("dyn_data", 32'(m_axis_tdata), 1111);
            check("dyn_mvalid", 32'(m_axis_tvalid), 1);
            @(negedge clk);
        end
        s_axis_tvalid = 3'b000;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("idle_count", 32'(dut.count), 32'(i % 3));
            check("idle_mvalid", 32'(m_axis_tvalid), 0);
            @(negedge clk);
        end

        // Asynchronous reset mid-operation while count is 2.
        s_axis_tvalid = 3'b111;
        s_axis_tdata  = pack3(100, 200, 300);
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("arst_pre_count", 32'(dut.count), 2);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_count", 32'(dut.count), 0);
        check("arst_mvalid", 32'(m_axis_tvalid), 0);
        check("arst_sready", 32'(s_axis_tready), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("arst_after_data", 32'(m_axis_tdata), 100);
        check("arst_after_mvalid", 32'(m_axis_tvalid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crossbar.md
CROSSBAR -- requirements
Module: crossbar

Interface
REQ-001 SHALL have parameter KERNEL_SIZE, default 3, meaning the number of input stream channels (K ≥ 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 18, meaning the bit width of each channel's data word.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port s_axis_tvalid  input  KERNEL_SIZE  per-channel valid; bit i belongs to channel i.
REQ-007 SHALL have port s_axis_tdata  input  DATA_WIDTH*KERNEL_SIZE  packed channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port s_axis_tready  output  KERNEL_SIZE  per-channel ready.
REQ-009 SHALL have port m_axis_tvalid  output  1  output stream valid.
REQ-010 SHALL have port m_axis_tdata  output  DATA_WIDTH  output stream data.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready.

Function
REQ-012 SHALL hold an internal register named count, width max(1, clog2(KERNEL_SIZE)), selecting the current channel; its range is 0..KERNEL_SIZE-1.
REQ-013 SHALL drive the output path combinationally, with zero latency: m_axis_tvalid = s_axis_tvalid[count], m_axis_tdata = channel count data.
REQ-014 SHALL drive s_axis_tready combinationally: bit count = m_axis_tready; all other bits 0.
REQ-015 SHALL count a transfer when m_axis_tvalid && m_axis_tready; channel count is then consumed in that same cycle.
REQ-016 SHALL advance count on the clock edge when a transfer occurs or when m_axis_tvalid = 0 (empty-channel skip).
REQ-017 SHALL hold count when m_axis_tvalid = 1 and m_axis_tready = 0 (backpressure freeze); data and valid stay stable.
REQ-018 SHALL compute the advance target as the first channel j with s_axis_tvalid[j] = 1, searching count+1, count+2, … count+K modulo K (round-robin; count itself is searched last).
REQ-019 SHALL set count to (count+1) mod K when no channel is valid, so the counter keeps cycling.
REQ-020 SHALL wrap from K-1 to 0, including for non-power-of-two K; count shall never exceed K-1.
REQ-021 SHALL, when only the current channel is valid and it transfers, keep count unchanged, allowing back-to-back transfers.
REQ-022 SHALL use the s_axis_tvalid value present at the clock edge, so a change of valid mid-round takes effect in the next selection.

Reset
REQ-023 SHALL force count to 0 asynchronously while rstn = 0.
REQ-024 SHALL, during reset, drive m_axis_tvalid to 0 and all s_axis_tready bits to 0, regardless of the inputs.
REQ-025 SHALL, on reset assertion mid-operation, abandon any in-flight selection with no transfer counted; after release, selection restarts at channel 0.

Structure
REQ-026 SHALL be a single module with no shared package; the count width shall be a localparam derived from KERNEL_SIZE.
REQ-027 SHALL contain one natural sub-module, rr_next_sel: a combinational round-robin next-valid finder with inputs count and valid vector, and outputs next index and an any_valid flag.

Verification
REQ-028 SHALL verify all-valid round robin: rstn 0→1, m_ready = 1, valid = 111, data 100/200/300 → transfers 100, 200, 300, 100, … with count 0, 1, 2, 0.
REQ-029 SHALL verify single channel: valid = 010, data 111/222/333 → count reaches 1 within one cycle, then 222 transfers every cycle; s_ready = 010.
REQ-030 SHALL verify backpressure: m_ready = 0, valid = 111, data 10/20/30 → count frozen, m_valid = 1, data stable, s_ready = 000; after m_ready = 1, transfers 10/20/30 resume in order from the frozen channel.
REQ-031 SHALL verify sparse channels: valid = 101, data 55/66/77 → transfers alternate 55, 77; 66 is never output; s_ready[1] = 0 always.
REQ-032 SHALL verify dynamic change and idle: valid 111 for two cycles, then 001 with data 1111 → after at most one skip, 1111 transfers each cycle; then valid = 000 → m_valid = 0 and count cycles 0, 1, 2.
REQ-033 SHALL verify reset mid-operation: assert rstn = 0 while count = 2 → count = 0 and m_valid = 0 immediately (asynchronous).
